// File: rtl/fpu_issue_scoreboard.sv
// Issue-stage hazard detector and sequencer for the single multi-cycle FPU.
// Tracks pending register writes from the FPU, the load currently in EX and
// the FPU latency countdown, and stalls decode whenever issuing would break
// RAW/WAW ordering, load-use timing, FPU occupancy or the writeback port.
module fpu_issue_scoreboard #(
  parameter int FPU_LAT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       IssueValid,
  input  logic       Flush,
  input  logic [0:4] Rs1,
  input  logic [0:4] Rs2,
  input  logic       Rs1Used,
  input  logic       Rs2Used,
  input  logic       Rs1FP,
  input  logic       Rs2FP,
  input  logic [0:4] Rd,
  input  logic       RdWE,
  input  logic       RdFP,
  input  logic [0:1] DInSrc,
  output logic       Stall,
  output logic       FPUStart,
  output logic       FPUDone,
  output logic       FPUBusy,
  output logic [0:4] FPUDest,
  output logic       FPUDestFP
);

  if (FPU_LAT < 4 || FPU_LAT > 15) begin : gLatCheck
    $error("fpu_issue_scoreboard: FPU_LAT must be in 4..15");
  end

  localparam logic [3:0] LAT = 4'(FPU_LAT);

  logic [31:0] gBusy, fBusy;
  logic [31:0] gBusyNext, fBusyNext;
  logic [3:0]  fpuCnt;
  logic        fpuDestWE;
  logic        ldValid;
  logic [0:4]  ldRd;
  logic        ldFP;

  logic isFpuOp, accept;
  logic raw1, raw2, waw, ldUse1, ldUse2, structHaz, wbHaz;

  // A register is pending if its busy bit is set; GPR R0 never is.
  function automatic logic isBusy(input logic [31:0] g, input logic [31:0] f,
                                  input logic [0:4] r, input logic fp);
    return fp ? f[r] : ((r != 5'd0) && g[r]);
  endfunction

  // The FPU result written this cycle is visible to a same-cycle reader.
  function automatic logic isBypass(input logic done, input logic we,
                                    input logic [0:4] dest, input logic destFp,
                                    input logic [0:4] r, input logic fp);
    return done && we && (dest == r) && (destFp == fp);
  endfunction

  // A source collides with the load in EX when number and file match (GPR R0 excluded).
  function automatic logic isLoadUse(input logic lv, input logic [0:4] lr, input logic lfp,
                                     input logic used, input logic [0:4] r, input logic fp);
    return lv && used && (lr == r) && (lfp == fp) && !(!fp && (r == 5'd0));
  endfunction

  // Hazard detection and issue decision, purely from state plus current decode.
  always_comb begin
    FPUDone   = (fpuCnt == 4'd1);
    FPUBusy   = (fpuCnt > 4'd1);
    isFpuOp   = (DInSrc == 2'b10);
    raw1      = Rs1Used && isBusy(gBusy, fBusy, Rs1, Rs1FP)
                && !isBypass(FPUDone, fpuDestWE, FPUDest, FPUDestFP, Rs1, Rs1FP);
    raw2      = Rs2Used && isBusy(gBusy, fBusy, Rs2, Rs2FP)
                && !isBypass(FPUDone, fpuDestWE, FPUDest, FPUDestFP, Rs2, Rs2FP);
    waw       = RdWE && isBusy(gBusy, fBusy, Rd, RdFP)
                && !isBypass(FPUDone, fpuDestWE, FPUDest, FPUDestFP, Rd, RdFP);
    ldUse1    = isLoadUse(ldValid, ldRd, ldFP, Rs1Used, Rs1, Rs1FP);
    ldUse2    = isLoadUse(ldValid, ldRd, ldFP, Rs2Used, Rs2, Rs2FP);
    structHaz = isFpuOp && (fpuCnt > 4'd1);
    wbHaz     = !isFpuOp && RdWE && (fpuCnt == 4'd4);
    Stall     = rst_n && IssueValid && !Flush
                && (raw1 || raw2 || waw || ldUse1 || ldUse2 || structHaz || wbHaz);
    accept    = rst_n && IssueValid && !Stall && !Flush;
    FPUStart  = accept && isFpuOp;
  end

  // Busy-bit update: completion clears first, a new FPU issue then sets (set wins).
  always_comb begin
    gBusyNext = gBusy;
    fBusyNext = fBusy;
    if (FPUDone && fpuDestWE) begin
      if (FPUDestFP) fBusyNext[FPUDest] = 1'b0;
      else           gBusyNext[FPUDest] = 1'b0;
    end
    if (FPUStart && RdWE) begin
      if (RdFP) fBusyNext[Rd] = 1'b1;
      else      gBusyNext[Rd] = 1'b1;
    end
    gBusyNext[0] = 1'b0;
  end

  // Scoreboard, FPU sequencer and load-in-EX tracking registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gBusy     <= '0;
      fBusy     <= '0;
      fpuCnt    <= '0;
      FPUDest   <= '0;
      FPUDestFP <= 1'b0;
      fpuDestWE <= 1'b0;
      ldValid   <= 1'b0;
      ldRd      <= '0;
      ldFP      <= 1'b0;
    end else begin
      gBusy <= gBusyNext;
      fBusy <= fBusyNext;
      if (FPUStart) begin
        fpuCnt    <= LAT;
        FPUDest   <= Rd;
        FPUDestFP <= RdFP;
        fpuDestWE <= RdWE;
      end else if (fpuCnt != 4'd0) begin
        fpuCnt <= fpuCnt - 4'd1;
      end
      ldValid <= accept && (DInSrc == 2'b11) && RdWE;
      ldRd    <= Rd;
      ldFP    <= RdFP;
    end
  end

endmodule

// File: tb/tb_fpu_issue_scoreboard.sv
// Directed bench for fpu_issue_scoreboard: stimulus pushes the hand-computed
// expected outputs for each cycle, a monitor pops and compares them.
module tb_fpu_issue_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       IssueValid = 1'b0, Flush = 1'b0;
  logic [0:4] Rs1 = '0, Rs2 = '0, Rd = '0;
  logic       Rs1Used = 1'b0, Rs2Used = 1'b0, Rs1FP = 1'b0, Rs2FP = 1'b0;
  logic       RdWE = 1'b0, RdFP = 1'b0;
  logic [0:1] DInSrc = '0;
  logic       Stall, FPUStart, FPUDone, FPUBusy, FPUDestFP;
  logic [0:4] FPUDest;

  typedef struct {
    logic iv, fl;
    logic [4:0] rs1; logic u1, f1;
    logic [4:0] rs2; logic u2, f2;
    logic [4:0] rd;  logic we, rfp;
    logic [1:0] din;
  } instrT;

  typedef struct {
    string name;
    logic [9:0] exp;
  } expT;

  expT q[$];
  int  checks = 0;
  int  errors = 0;

  fpu_issue_scoreboard #(.FPU_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n), .IssueValid(IssueValid), .Flush(Flush),
    .Rs1(Rs1), .Rs2(Rs2), .Rs1Used(Rs1Used), .Rs2Used(Rs2Used),
    .Rs1FP(Rs1FP), .Rs2FP(Rs2FP), .Rd(Rd), .RdWE(RdWE), .RdFP(RdFP),
    .DInSrc(DInSrc), .Stall(Stall), .FPUStart(FPUStart), .FPUDone(FPUDone),
    .FPUBusy(FPUBusy), .FPUDest(FPUDest), .FPUDestFP(FPUDestFP)
  );

  always #5 clk = ~clk;

  function automatic instrT mk(logic iv, logic fl, int rs1, logic u1, logic f1,
                               int rs2, logic u2, logic f2, int rd, logic we,
                               logic rfp, logic [1:0] din);
    instrT i;
    i.iv = iv; i.fl = fl;
    i.rs1 = 5'(rs1); i.u1 = u1; i.f1 = f1;
    i.rs2 = 5'(rs2); i.u2 = u2; i.f2 = f2;
    i.rd = 5'(rd); i.we = we; i.rfp = rfp; i.din = din;
    return i;
  endfunction

  function automatic instrT nop();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
  endfunction
  function automatic instrT fpuOp(int rd, int rs1, int rs2);
    return mk(1, 0, rs1, 1, 1, rs2, 1, 1, rd, 1, 1, 2'b10);
  endfunction
  function automatic instrT fpuOpFlushed(int rd, int rs1, int rs2);
    return mk(1, 1, rs1, 1, 1, rs2, 1, 1, rd, 1, 1, 2'b10);
  endfunction
  function automatic instrT alu(int rd, int rs1, int rs2);
    return mk(1, 0, rs1, 1, 0, rs2, 1, 0, rd, 1, 0, 2'b01);
  endfunction
  function automatic instrT load(int rd, int rs1);
    return mk(1, 0, rs1, 1, 0, 0, 0, 0, rd, 1, 0, 2'b11);
  endfunction
  function automatic instrT storeG(int rs1, int rs2);
    return mk(1, 0, rs1, 1, 0, rs2, 1, 0, 0, 0, 0, 2'b01);
  endfunction
  function automatic instrT storeF(int rs1, int rs2);
    return mk(1, 0, rs1, 1, 0, rs2, 1, 1, 0, 0, 0, 2'b01);
  endfunction

  // Drive one cycle of decode inputs and queue the outputs expected that cycle.
  task automatic applyStimulus(input string name, input instrT ins, input logic rstn,
                               input logic eStall, input logic eStart, input logic eDone,
                               input logic eBusy, input int eDest, input logic eDestFP);
    expT e;
    @(posedge clk);
    #1;
    rst_n = rstn;
    IssueValid = ins.iv; Flush = ins.fl;
    Rs1 = ins.rs1; Rs1Used = ins.u1; Rs1FP = ins.f1;
    Rs2 = ins.rs2; Rs2Used = ins.u2; Rs2FP = ins.f2;
    Rd = ins.rd; RdWE = ins.we; RdFP = ins.rfp; DInSrc = ins.din;
    e.name = name;
    e.exp = {eStall, eStart, eDone, eBusy, 5'(eDest), eDestFP};
    q.push_back(e);
  endtask

  // Compare the DUT outputs against one queued expectation.
  task automatic checkOutput(input expT e);
    logic [9:0] act;
    act = {Stall, FPUStart, FPUDone, FPUBusy, FPUDest, FPUDestFP};
    checks++;
    if (act !== e.exp) begin
      errors++;
      $display("[TB] FAIL %s: stall/start/done/busy/dest/destFP got %b_%b_%b_%b_%0d_%b required %b_%b_%b_%b_%0d_%b",
               e.name, act[9], act[8], act[7], act[6], act[5:1], act[0],
               e.exp[9], e.exp[8], e.exp[7], e.exp[6], e.exp[5:1], e.exp[0]);
    end
  endtask

  // Monitor: outputs are presented every cycle, so check mid-cycle on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) checkOutput(q.pop_front());
    end
  end

  initial begin
    @(posedge clk);

    // Reset held with an FPU op presented
    for (int i = 0; i < 3; i++) applyStimulus("rst_hold", fpuOp(1, 10, 11), 1'b0, 0, 0, 0, 0, 0, 0);
    applyStimulus("rst_first_start", fpuOp(1, 10, 11), 1'b1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus("rst_first_busy", nop(), 1'b1, 0, 0, 0, 1, 1, 1);
    applyStimulus("rst_first_done", nop(), 1'b1, 0, 0, 1, 0, 1, 1);

    // Load-use, and the R0 exception
    applyStimulus("lu_lw_r3", load(3, 2), 1'b1, 0, 0, 0, 0, 1, 1);
    applyStimulus("lu_add_stall", alu(5, 3, 1), 1'b1, 1, 0, 0, 0, 1, 1);
    applyStimulus("lu_add_accept", alu(5, 3, 1), 1'b1, 0, 0, 0, 0, 1, 1);
    applyStimulus("lu_lw_r0", load(0, 2), 1'b1, 0, 0, 0, 0, 1, 1);
    applyStimulus("lu_r0_nostall", alu(5, 0, 1), 1'b1, 0, 0, 0, 0, 1, 1);

    // FPU RAW with write-before-read bypass
    applyStimulus("raw_multf_f2", fpuOp(2, 6, 7), 1'b1, 0, 1, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) applyStimulus("raw_addf_stall", fpuOp(4, 2, 6), 1'b1, 1, 0, 0, 1, 2, 1);
    applyStimulus("raw_addf_bypass", fpuOp(4, 2, 6), 1'b1, 0, 1, 1, 0, 2, 1);
    applyStimulus("raw_f2_cleared", storeF(1, 2), 1'b1, 0, 0, 0, 1, 4, 1);
    applyStimulus("raw_f4_busy", storeF(1, 4), 1'b1, 1, 0, 0, 1, 4, 1);
    applyStimulus("raw_drain", nop(), 1'b1, 0, 0, 0, 1, 4, 1);
    applyStimulus("raw_drain_done", nop(), 1'b1, 0, 0, 1, 0, 4, 1);

    // Writeback collision and FPU structural hazard
    applyStimulus("st_fpu_a", fpuOp(10, 1, 3), 1'b1, 0, 1, 0, 0, 4, 1);
    applyStimulus("st_add_wbcoll", alu(7, 1, 2), 1'b1, 1, 0, 0, 1, 10, 1);
    applyStimulus("st_add_accept", alu(7, 1, 2), 1'b1, 0, 0, 0, 1, 10, 1);
    applyStimulus("st_fpu_b_stall", fpuOp(11, 1, 3), 1'b1, 1, 0, 0, 1, 10, 1);
    applyStimulus("st_fpu_b_b2b", fpuOp(11, 1, 3), 1'b1, 0, 1, 1, 0, 10, 1);
    applyStimulus("st_sw_nostall", storeG(1, 2), 1'b1, 0, 0, 0, 1, 11, 1);
    applyStimulus("st_fpu_c_stall", fpuOp(12, 1, 3), 1'b1, 1, 0, 0, 1, 11, 1);
    applyStimulus("st_fpu_c_stall", fpuOp(12, 1, 3), 1'b1, 1, 0, 0, 1, 11, 1);
    applyStimulus("st_fpu_c_b2b", fpuOp(12, 1, 3), 1'b1, 0, 1, 1, 0, 11, 1);
    for (int i = 0; i < 3; i++) applyStimulus("st_drain", nop(), 1'b1, 0, 0, 0, 1, 12, 1);
    applyStimulus("st_drain_done", nop(), 1'b1, 0, 0, 1, 0, 12, 1);

    // WAW with set-wins on the same destination
    applyStimulus("waw_multf_f8", fpuOp(8, 1, 3), 1'b1, 0, 1, 0, 0, 12, 1);
    for (int i = 0; i < 3; i++) applyStimulus("waw_addf_stall", fpuOp(8, 1, 3), 1'b1, 1, 0, 0, 1, 8, 1);
    applyStimulus("waw_addf_accept", fpuOp(8, 1, 3), 1'b1, 0, 1, 1, 0, 8, 1);
    for (int i = 0; i < 3; i++) applyStimulus("waw_f8_still_busy", storeF(1, 8), 1'b1, 1, 0, 0, 1, 8, 1);
    applyStimulus("waw_f8_bypass", storeF(1, 8), 1'b1, 0, 0, 1, 0, 8, 1);
    applyStimulus("waw_f8_clear", storeF(1, 8), 1'b1, 0, 0, 0, 0, 8, 1);

    // Flush and reset in the middle of an FPU op
    applyStimulus("fl_flushed_op", fpuOpFlushed(13, 1, 3), 1'b1, 0, 0, 0, 0, 8, 1);
    applyStimulus("fl_f13_not_busy", storeF(1, 13), 1'b1, 0, 0, 0, 0, 8, 1);
    applyStimulus("mr_fpu_start", fpuOp(14, 1, 3), 1'b1, 0, 1, 0, 0, 8, 1);
    applyStimulus("mr_busy", nop(), 1'b1, 0, 0, 0, 1, 14, 1);
    applyStimulus("mr_reset_cycle", nop(), 1'b0, 0, 0, 0, 1, 14, 1);
    for (int i = 0; i < 3; i++) applyStimulus("mr_no_done", nop(), 1'b1, 0, 0, 0, 0, 0, 0);
    applyStimulus("mr_f14_cleared", storeF(1, 14), 1'b1, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
